// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared types and constants for the ALU issue stage: the data word, the
//   ALU op code enum, RV32I opcode/funct constants, the decode record and
//   the decoder for the supported integer ALU subset.
package alu_issue_pkg;

    typedef logic [31:0] word;

    localparam int REG_AW = 5;
    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [2:0] {
        ALU_NONE = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_SRA  = 3'b101
    } alu_op_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_SRA = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // legal:   instruction belongs to the supported subset
    // is_r:    register-register form (rs2 is a real source)
    // use_imm: operand1 comes from the instruction, not rs2
    typedef struct packed {
        logic    legal;
        logic    is_r;
        logic    use_imm;
        alu_op_t op;
    } decode_t;

    function automatic decode_t decode(input word instr);
        decode_t    d;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];
        d = '{legal: 1'b0, is_r: 1'b0, use_imm: 1'b0, op: ALU_NONE};
        if (opcode == OP_R) begin
            d.is_r = 1'b1;
            case (funct3)
                F3_ADD: begin
                    if (funct7 == F7_BASE)     d.op = ALU_ADD;
                    else if (funct7 == F7_ALT) d.op = ALU_SUB;
                end
                F3_XOR: if (funct7 == F7_BASE) d.op = ALU_XOR;
                F3_AND: if (funct7 == F7_BASE) d.op = ALU_AND;
                F3_SRA: if (funct7 == F7_ALT)  d.op = ALU_SRA;
                default: ;
            endcase
        end else if (opcode == OP_I) begin
            d.use_imm = 1'b1;
            case (funct3)
                F3_ADD: d.op = ALU_ADD;
                F3_XOR: d.op = ALU_XOR;
                F3_AND: d.op = ALU_AND;
                // imm[11:5] selects SRAI; any other pattern (e.g. SRLI) is unsupported
                F3_SRA: if (funct7 == F7_ALT) d.op = ALU_SRA;
                default: ;
            endcase
        end
        d.legal = (d.op != ALU_NONE);
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if
//   Bundles the issue stage's handshake and data signals:
//     instruction in : i_instr_valid, i_instr, o_instr_ready
//     ALU bundle out : o_issue_valid, i_issue_ready, o_ALUOp, o_operand0,
//                      o_operand1, o_rd
//     writeback in   : i_wb_valid, i_wb_rd, i_wb_data
//     status out     : o_illegal
//   slave  = the issue stage's view, master = the environment's view.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic      i_instr_valid;
    word       i_instr;
    logic      o_instr_ready;
    logic      o_issue_valid;
    logic      i_issue_ready;
    alu_op_t   o_ALUOp;
    word       o_operand0;
    word       o_operand1;
    reg_addr_t o_rd;
    logic      i_wb_valid;
    reg_addr_t i_wb_rd;
    word       i_wb_data;
    logic      o_illegal;

    modport slave (
        input  i_instr_valid, i_instr, i_issue_ready,
        input  i_wb_valid, i_wb_rd, i_wb_data,
        output o_instr_ready, o_issue_valid, o_ALUOp,
        output o_operand0, o_operand1, o_rd, o_illegal
    );

    modport master (
        output i_instr_valid, i_instr, i_issue_ready,
        output i_wb_valid, i_wb_rd, i_wb_data,
        input  o_instr_ready, o_issue_valid, o_ALUOp,
        input  o_operand0, o_operand1, o_rd, o_illegal
    );

endinterface

// File: rtl/alu_issue_regfile_scoreboard.sv
// alu_issue_regfile_scoreboard
//   Register file plus per-register busy scoreboard for the issue stage.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     rs1_addr, rs2_addr, rd_addr source/destination of the candidate instr
//     rs1_data, rs2_data          combinational read data (x0 reads 0)
//     rs1_busy, rs2_busy, rd_busy busy state as seen by the hazard check
//     set_en                      an instruction issues this cycle (marks rd)
//     wb_valid, wb_addr, wb_data  writeback port (writes reg, clears busy)
//   With WB_BYPASS != 0 a same-cycle writeback is forwarded into the reads
//   and hides that register's busy bit.
module alu_issue_regfile_scoreboard
    import alu_issue_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  reg_addr_t rd_addr,
    output word       rs1_data,
    output word       rs2_data,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      rd_busy,
    input  logic      set_en,
    input  logic      wb_valid,
    input  reg_addr_t wb_addr,
    input  word       wb_data
);

    localparam bit BYPASS = (WB_BYPASS != 0);

    word                 regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_eff;
    logic                wb_live;

    // Writebacks to x0 are dropped entirely.
    assign wb_live = wb_valid && (wb_addr != '0);

    // NOTE: every always_comb output gets a default assignment first so no
    // path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (BYPASS && wb_live && (wb_addr == rs1_addr)) ? wb_data : regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = (BYPASS && wb_live && (wb_addr == rs2_addr)) ? wb_data : regs[rs2_addr];
        end
    end

    always_comb begin
        busy_eff = busy;
        if (BYPASS && wb_live) begin
            busy_eff[wb_addr] = 1'b0;
        end
        busy_eff[0] = 1'b0;
    end

    assign rs1_busy = busy_eff[rs1_addr];
    assign rs2_busy = busy_eff[rs2_addr];
    assign rd_busy  = busy_eff[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register array is architecturally zero after reset,
            // so it is reset here along with the busy vector.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
                busy[wb_addr] <= 1'b0;
            end
            // Last non-blocking assignment wins: an issue targeting the same
            // rd as the writeback leaves the register busy.
            if (set_en && (rd_addr != '0)) begin
                busy[rd_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Issue stage in front of the execute ALU. Decodes the RV32I integer ALU
//   subset, reads operands, enforces the busy scoreboard and holds one
//   registered op/operand bundle for the ALU under valid/ready flow control.
//   Ports:
//     i_clk, i_rst_n  clock, async active-low reset
//     io              alu_issue_if.slave: instruction in, ALU bundle out,
//                     writeback in, illegal-instruction pulse out
//   Parameters:
//     NUM_REGS        architectural register count (x0 hardwired to zero)
//     WB_BYPASS       1: same-cycle writeback forwards and clears its hazard
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    alu_issue_if.slave io
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t    state;
    decode_t   dec;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    reg_addr_t rd_addr;
    word       rs1_data;
    word       rs2_data;
    word       operand1_next;
    logic      rs1_busy;
    logic      rs2_busy;
    logic      rd_busy;
    logic      hazard;
    logic      instr_ready;
    logic      accept;
    logic      issue;

    logic      issue_valid_q;
    logic      illegal_q;
    alu_op_t   alu_op_q;
    word       operand0_q;
    word       operand1_q;
    reg_addr_t rd_q;

    assign dec      = decode(io.i_instr);
    assign rs1_addr = io.i_instr[19:15];
    assign rs2_addr = io.i_instr[24:20];
    assign rd_addr  = io.i_instr[11:7];

    alu_issue_regfile_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .WB_BYPASS (WB_BYPASS)
    ) u_rf (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_addr  (rd_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .set_en   (issue),
        .wb_valid (io.i_wb_valid),
        .wb_addr  (io.i_wb_rd),
        .wb_data  (io.i_wb_data)
    );

    // Illegal instructions never stall: they only pulse o_illegal. The rs2
    // field of an I-type is immediate bits, so only R-type checks rs2.
    assign hazard      = dec.legal && (rs1_busy || (dec.is_r && rs2_busy) || rd_busy);
    assign instr_ready = ((state == ST_EMPTY) || io.i_issue_ready) && !hazard;
    assign accept      = io.i_instr_valid && instr_ready;
    assign issue       = accept && dec.legal;

    // Shift amounts are 5 bits: SRA takes rs2[4:0], SRAI takes the shamt field.
    always_comb begin
        operand1_next = rs2_data;
        if (dec.use_imm) begin
            if (dec.op == ALU_SRA) operand1_next = {27'b0, io.i_instr[24:20]};
            else                   operand1_next = {{20{io.i_instr[31]}}, io.i_instr[31:20]};
        end else if (dec.op == ALU_SRA) begin
            operand1_next = {27'b0, rs2_data[4:0]};
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so all
    // of them update together from the pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_EMPTY;
            issue_valid_q <= 1'b0;
            alu_op_q      <= ALU_NONE;
            operand0_q    <= '0;
            operand1_q    <= '0;
            rd_q          <= '0;
            illegal_q     <= 1'b0;
        end else begin
            illegal_q <= accept && !dec.legal;
            case (state)
                ST_EMPTY: begin
                    if (issue) begin
                        state         <= ST_FULL;
                        issue_valid_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // Consumed with nothing new behind it: drain to EMPTY.
                    // Consumed and refilled in one cycle: stay FULL.
                    if (!issue && io.i_issue_ready) begin
                        state         <= ST_EMPTY;
                        issue_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_EMPTY;
                    issue_valid_q <= 1'b0;
                end
            endcase
            if (issue) begin
                alu_op_q   <= dec.op;
                operand0_q <= rs1_data;
                operand1_q <= operand1_next;
                rd_q       <= rd_addr;
            end
        end
    end

    assign io.o_instr_ready = instr_ready;
    assign io.o_issue_valid = issue_valid_q;
    assign io.o_ALUOp       = alu_op_q;
    assign io.o_operand0    = operand0_q;
    assign io.o_operand1    = operand1_q;
    assign io.o_rd          = rd_q;
    assign io.o_illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Bench for alu_issue: a bypassing instance (dut) covers reset, a decode
//   vector table, hazards, backpressure and reset mid-bundle; a second
//   instance with WB_BYPASS=0 (dut_nb) covers the non-bypass stall.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_if io ();
    alu_issue_if io_nb ();

    alu_issue #(.NUM_REGS(32), .WB_BYPASS(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io      (io.slave)
    );

    alu_issue #(.NUM_REGS(32), .WB_BYPASS(0)) dut_nb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io      (io_nb.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        word        instr;
        logic       illegal;
        logic [2:0] op;
        word        op0;
        word        op1;
        logic [4:0] rd;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input word actual, input word expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_cycle(input logic [4:0] rd, input word data);
        io.i_wb_valid = 1'b1;
        io.i_wb_rd    = rd;
        io.i_wb_data  = data;
        tick();
        io.i_wb_valid = 1'b0;
    endtask

    function automatic word enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                  input logic [4:0] rs1, input logic [2:0] f3,
                                  input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic word enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                  input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, OP_I};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word mask;

        // Registers preloaded before the table: x1=10, x2=0x23, x7=0x80000000.
        vecs[0]  = '{enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd10), 1'b0, 3'b001, 32'd10,        32'h23,        5'd10};
        vecs[1]  = '{enc_r(F7_ALT,  5'd2, 5'd1, F3_ADD, 5'd11), 1'b0, 3'b010, 32'd10,        32'h23,        5'd11};
        vecs[2]  = '{enc_r(F7_BASE, 5'd1, 5'd7, F3_XOR, 5'd12), 1'b0, 3'b011, 32'h8000_0000, 32'd10,        5'd12};
        vecs[3]  = '{enc_r(F7_BASE, 5'd7, 5'd2, F3_AND, 5'd13), 1'b0, 3'b100, 32'h23,        32'h8000_0000, 5'd13};
        vecs[4]  = '{enc_r(F7_ALT,  5'd2, 5'd1, F3_SRA, 5'd14), 1'b0, 3'b101, 32'd10,        32'd3,         5'd14};
        vecs[5]  = '{enc_i(12'hFFF, 5'd1, F3_ADD, 5'd15),       1'b0, 3'b001, 32'd10,        32'hFFFF_FFFF, 5'd15};
        vecs[6]  = '{enc_i(12'h7FF, 5'd7, F3_XOR, 5'd16),       1'b0, 3'b011, 32'h8000_0000, 32'h7FF,       5'd16};
        vecs[7]  = '{enc_i(12'h800, 5'd2, F3_AND, 5'd17),       1'b0, 3'b100, 32'h23,        32'hFFFF_F800, 5'd17};
        vecs[8]  = '{enc_i({F7_ALT, 5'd31}, 5'd1, F3_SRA, 5'd18), 1'b0, 3'b101, 32'd10,      32'd31,        5'd18};
        vecs[9]  = '{enc_i(12'd5, 5'd0, F3_ADD, 5'd0),          1'b0, 3'b001, 32'd0,         32'd5,         5'd0};
        vecs[10] = '{enc_r(F7_BASE, 5'd2, 5'd0, F3_ADD, 5'd19), 1'b0, 3'b001, 32'd0,         32'h23,        5'd19};
        vecs[11] = '{enc_r(F7_BASE, 5'd3, 5'd2, 3'b110, 5'd1),  1'b1, 3'b000, 32'd0,         32'd0,         5'd0};
        vecs[12] = '{enc_r(F7_ALT,  5'd2, 5'd1, F3_XOR, 5'd12), 1'b1, 3'b000, 32'd0,         32'd0,         5'd0};
        vecs[13] = '{enc_i({F7_BASE, 5'd3}, 5'd1, F3_SRA, 5'd18), 1'b1, 3'b000, 32'd0,       32'd0,         5'd0};
        vecs[14] = '{{20'h12345, 5'd1, 7'b0110111},             1'b1, 3'b000, 32'd0,         32'd0,         5'd0};

        io.i_instr_valid = 1'b0; io.i_instr = '0; io.i_issue_ready = 1'b0;
        io.i_wb_valid = 1'b0; io.i_wb_rd = '0; io.i_wb_data = '0;
        io_nb.i_instr_valid = 1'b0; io_nb.i_instr = '0; io_nb.i_issue_ready = 1'b0;
        io_nb.i_wb_valid = 1'b0; io_nb.i_wb_rd = '0; io_nb.i_wb_data = '0;
        rst_n = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst valid",   32'(io.o_issue_valid), 32'd0);
        check("rst aluop",   32'(io.o_ALUOp),       32'd0);
        check("rst op0",     io.o_operand0,         32'd0);
        check("rst op1",     io.o_operand1,         32'd0);
        check("rst rd",      32'(io.o_rd),          32'd0);
        check("rst illegal", 32'(io.o_illegal),     32'd0);
        check("rst busy",    dut.u_rf.busy,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- ADDI x1,x0,5 then writeback x1 ----
        io.i_issue_ready = 1'b1;
        io.i_instr = enc_i(12'd5, 5'd0, F3_ADD, 5'd1);
        io.i_instr_valid = 1'b1;
        #1 check("addi ready", 32'(io.o_instr_ready), 32'd1);
        tick();
        io.i_instr_valid = 1'b0;
        check("addi valid", 32'(io.o_issue_valid), 32'd1);
        check("addi aluop", 32'(io.o_ALUOp),       32'd1);
        check("addi op0",   io.o_operand0,         32'd0);
        check("addi op1",   io.o_operand1,         32'd5);
        check("addi rd",    32'(io.o_rd),          32'd1);
        check("addi busy1", 32'(dut.u_rf.busy[1]), 32'd1);
        wb_cycle(5'd1, 32'd5);
        check("wb busy1 clr", 32'(dut.u_rf.busy[1]), 32'd0);
        check("wb x1 data",   dut.u_rf.regs[1],      32'd5);
        check("addi drained", 32'(io.o_issue_valid), 32'd0);

        // ---- preload sources (writebacks to non-busy registers) ----
        wb_cycle(5'd1, 32'd10);
        wb_cycle(5'd2, 32'h23);
        wb_cycle(5'd7, 32'h8000_0000);

        // ---- decode vector table ----
        for (int i = 0; i < NVEC; i++) begin
            io.i_instr = vecs[i].instr;
            io.i_instr_valid = 1'b1;
            io.i_issue_ready = 1'b1;
            #1 check($sformatf("vec%0d ready", i), 32'(io.o_instr_ready), 32'd1);
            tick();
            io.i_instr_valid = 1'b0;
            check($sformatf("vec%0d valid", i),   32'(io.o_issue_valid), 32'(!vecs[i].illegal));
            check($sformatf("vec%0d illegal", i), 32'(io.o_illegal),     32'(vecs[i].illegal));
            if (!vecs[i].illegal) begin
                check($sformatf("vec%0d aluop", i), 32'(io.o_ALUOp),  32'(vecs[i].op));
                check($sformatf("vec%0d op0", i),   io.o_operand0,    vecs[i].op0);
                check($sformatf("vec%0d op1", i),   io.o_operand1,    vecs[i].op1);
                check($sformatf("vec%0d rd", i),    32'(io.o_rd),     32'(vecs[i].rd));
            end
            mask = '0;
            if (!vecs[i].illegal && vecs[i].rd != 5'd0) mask[vecs[i].rd] = 1'b1;
            check($sformatf("vec%0d busy", i), dut.u_rf.busy, mask);
            if (!vecs[i].illegal && vecs[i].rd != 5'd0) begin
                io.i_wb_valid = 1'b1; io.i_wb_rd = vecs[i].rd; io.i_wb_data = '0;
            end
            tick();
            io.i_wb_valid = 1'b0;
            check($sformatf("vec%0d drained", i), 32'(io.o_issue_valid), 32'd0);
            check($sformatf("vec%0d pulse", i),   32'(io.o_illegal),     32'd0);
        end

        // ---- RAW hazard, bypassing instance ----
        io.i_issue_ready = 1'b1;
        io.i_instr = enc_i(12'd1, 5'd0, F3_ADD, 5'd5);
        io.i_instr_valid = 1'b1;
        tick();
        io.i_instr = enc_r(F7_BASE, 5'd5, 5'd5, F3_ADD, 5'd6);
        #1 check("raw stall", 32'(io.o_instr_ready), 32'd0);
        tick();
        check("raw stall2",  32'(io.o_instr_ready), 32'd0);
        check("raw bubble",  32'(io.o_issue_valid), 32'd0);
        io.i_wb_valid = 1'b1; io.i_wb_rd = 5'd5; io.i_wb_data = 32'h1234;
        #1 check("byp ready", 32'(io.o_instr_ready), 32'd1);
        tick();
        io.i_wb_valid = 1'b0;
        io.i_instr_valid = 1'b0;
        check("byp valid", 32'(io.o_issue_valid), 32'd1);
        check("byp op0",   io.o_operand0,          32'h1234);
        check("byp op1",   io.o_operand1,          32'h1234);
        check("byp rd",    32'(io.o_rd),           32'd6);
        check("byp busy",  dut.u_rf.busy,          32'h0000_0040);
        wb_cycle(5'd6, 32'd0);

        // ---- RAW hazard, non-bypassing instance ----
        io_nb.i_issue_ready = 1'b1;
        io_nb.i_instr = enc_i(12'd1, 5'd0, F3_ADD, 5'd5);
        io_nb.i_instr_valid = 1'b1;
        tick();
        io_nb.i_instr = enc_r(F7_BASE, 5'd5, 5'd5, F3_ADD, 5'd6);
        #1 check("nb stall", 32'(io_nb.o_instr_ready), 32'd0);
        io_nb.i_wb_valid = 1'b1; io_nb.i_wb_rd = 5'd5; io_nb.i_wb_data = 32'h55;
        #1 check("nb wb stall", 32'(io_nb.o_instr_ready), 32'd0);
        tick();
        io_nb.i_wb_valid = 1'b0;
        #1 check("nb ready", 32'(io_nb.o_instr_ready), 32'd1);
        check("nb not taken", 32'(io_nb.o_issue_valid), 32'd0);
        tick();
        io_nb.i_instr_valid = 1'b0;
        check("nb valid", 32'(io_nb.o_issue_valid), 32'd1);
        check("nb op0",   io_nb.o_operand0,         32'h55);
        check("nb op1",   io_nb.o_operand1,         32'h55);
        check("nb rd",    32'(io_nb.o_rd),          32'd6);

        // ---- issue and writeback to same rd: set wins ----
        io.i_instr = enc_i(12'd7, 5'd0, F3_ADD, 5'd8);
        io.i_instr_valid = 1'b1;
        io.i_wb_valid = 1'b1; io.i_wb_rd = 5'd8; io.i_wb_data = 32'h99;
        tick();
        io.i_instr_valid = 1'b0;
        io.i_wb_valid = 1'b0;
        check("setwin busy", dut.u_rf.busy,    32'h0000_0100);
        check("setwin data", dut.u_rf.regs[8], 32'h99);
        io.i_instr = enc_r(F7_BASE, 5'd0, 5'd8, F3_ADD, 5'd9);
        io.i_instr_valid = 1'b1;
        #1 check("setwin stall", 32'(io.o_instr_ready), 32'd0);
        io.i_instr_valid = 1'b0;
        wb_cycle(5'd8, 32'd0);
        check("setwin clr", dut.u_rf.busy, 32'd0);

        // ---- backpressure and back-to-back issue ----
        io.i_issue_ready = 1'b0;
        io.i_instr = enc_i(12'h11, 5'd0, F3_ADD, 5'd20);
        io.i_instr_valid = 1'b1;
        #1 check("bp empty ready", 32'(io.o_instr_ready), 32'd1);
        tick();
        io.i_instr = enc_i(12'h22, 5'd0, F3_ADD, 5'd21);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d valid", k), 32'(io.o_issue_valid), 32'd1);
            check($sformatf("bp%0d op1", k),   io.o_operand1,         32'h11);
            check($sformatf("bp%0d rd", k),    32'(io.o_rd),          32'd20);
            check($sformatf("bp%0d ready", k), 32'(io.o_instr_ready), 32'd0);
            tick();
        end
        io.i_issue_ready = 1'b1;
        #1 check("b2b ready", 32'(io.o_instr_ready), 32'd1);
        tick();
        io.i_instr_valid = 1'b0;
        check("b2b valid", 32'(io.o_issue_valid), 32'd1);
        check("b2b op1",   io.o_operand1,         32'h22);
        check("b2b rd",    32'(io.o_rd),          32'd21);
        tick();
        check("b2b drain", 32'(io.o_issue_valid), 32'd0);
        wb_cycle(5'd20, 32'd0);
        wb_cycle(5'd21, 32'd0);

        // ---- asynchronous reset while FULL ----
        io.i_issue_ready = 1'b0;
        io.i_instr = enc_i(12'd3, 5'd0, F3_ADD, 5'd22);
        io.i_instr_valid = 1'b1;
        tick();
        io.i_instr_valid = 1'b0;
        check("full valid", 32'(io.o_issue_valid), 32'd1);
        check("full busy",  dut.u_rf.busy,         32'h0040_0000);
        #2 rst_n = 1'b0;
        #1;
        check("arst valid", 32'(io.o_issue_valid), 32'd0);
        check("arst aluop", 32'(io.o_ALUOp),       32'd0);
        check("arst op1",   io.o_operand1,         32'd0);
        check("arst rd",    32'(io.o_rd),          32'd0);
        check("arst busy",  dut.u_rf.busy,         32'd0);
        check("arst x1",    dut.u_rf.regs[1],      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post rst valid", 32'(io.o_issue_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage directly upstream of the execute ALU.
- Accepts one 32-bit RV32I instruction per handshake and decodes the integer ALU subset into the ALU's 3-bit op code.
- Reads operands from an internal 32x32 register file, applies a per-register busy scoreboard, and presents a registered op/operand bundle to the ALU with valid/ready flow control.
- The writeback port retires ALU results into the register file and clears scoreboard bits.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is hardwired to zero.
- WB_BYPASS, 1, when 1 a same-cycle writeback forwards into the operand read and clears that hazard.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_instr_valid  input  1  upstream instruction valid.
- i_instr  input  word  RV32I instruction.
- o_instr_ready  output  1  stage accepts i_instr this cycle.
- o_issue_valid  output  1  ALU bundle valid.
- i_issue_ready  input  1  ALU side consumes the bundle.
- o_ALUOp  output  3  ALU op code: 001 ADD, 010 SUB, 011 XOR, 100 AND, 101 SRA, 000 none.
- o_operand0  output  word  rs1 value.
- o_operand1  output  word  rs2 value or immediate.
- o_rd  output  5  destination register of the issued op.
- i_wb_valid  input  1  writeback strobe.
- i_wb_rd  input  5  writeback destination.
- i_wb_data  input  word  writeback value.
- o_illegal  output  1  one-cycle pulse when an unsupported instruction is consumed.

Behaviour:
- Reset, asynchronous, while i_rst_n=0:
  - o_issue_valid=0, o_ALUOp=000, o_operand0/1=0, o_rd=0, o_illegal=0.
  - Busy vector cleared; all registers 0.
  - Any bundle in flight is discarded.
- Output FSM:
  - EMPTY: o_issue_valid=0.
  - FULL: o_issue_valid=1; the bundle is held stable until i_issue_ready=1.
  - FULL->EMPTY when i_issue_ready=1 and nothing new is accepted.
  - FULL->FULL with a new bundle when consumed and accepted in the same cycle.
- o_instr_ready = (EMPTY or i_issue_ready) and no hazard. Hazard means busy[rs1], busy[rs2] (R-type only) or busy[rd], for any register other than x0.
- Latency: one cycle. An instruction accepted at edge N has its bundle valid after edge N.
- Decode, R-type (opcode 0110011):
  - funct3 000 with funct7 0000000 -> ADD; with funct7 0100000 -> SUB.
  - funct3 100 with funct7 0 -> XOR.
  - funct3 111 with funct7 0 -> AND.
  - funct3 101 with funct7 0100000 -> SRA; o_operand1 = {27'b0, rs2val[4:0]}.
- Decode, I-type (opcode 0010011):
  - ADDI (funct3 000), XORI (100), ANDI (111): o_operand1 = sign-extended imm[11:0].
  - SRAI (101 with imm[11:5]=0100000): o_operand1 = {27'b0, shamt}.
- Illegal instructions:
  - Anything else is illegal. It is consumed when o_instr_ready=1, o_illegal pulses one cycle, no bundle is produced, and the scoreboard is unchanged.
  - The hazard check does not apply to illegal instructions.
- Scoreboard:
  - On issue with rd!=0, busy[rd] is set at the accept edge.
  - i_wb_valid with i_wb_rd!=0 writes the register file and clears busy[i_wb_rd].
  - A writeback to x0 is ignored.
  - A writeback to a non-busy register still writes the data; busy stays 0.
- Simultaneous events:
  - With WB_BYPASS=1, a writeback in the accept cycle counts as not-busy for its register and forwards i_wb_data as the operand value.
  - If writeback and issue target the same rd in one cycle, the set wins: busy=1 and the register holds the wb data.
  - With WB_BYPASS=0, a same-cycle writeback does not lift the stall; the instruction is accepted the next cycle.
- Register reads are combinational at accept; x0 always reads 0.

Decomposition:
- Shared Types package:
  - word (existing).
  - alu_op_t enum with the 3-bit codes above.
  - RV opcode constants OP_R=7'b0110011 and OP_I=7'b0010011.
  - funct3/funct7 constants.
- One natural sub-module: regfile_scoreboard. It holds the register array, the busy vector, two read ports with wb bypass, the write port, and the set/clear logic.
- Decode and the output FSM stay in alu_issue.

Test Plan:
- ADDI x1,x0,5 with i_issue_ready=1 -> next cycle o_issue_valid=1, o_ALUOp=001, operands 0 and 5, o_rd=1, busy[1]=1. Then wb x1=5 -> busy[1]=0.
- SUB x3,x1,x2 with x1=10 and x2=3 -> o_ALUOp=010, operands 10 and 3.
- SRAI x4,x1,31 with imm[11:5]=0100000 -> o_ALUOp=101, o_operand1=31. SRA x4,x1,x2 with x2=0x23 -> o_operand1=3.
- RAW hazard: ADDI x5,x0,1, then ADD x6,x5,x5 -> o_instr_ready=0 until wb x5.
  - WB_BYPASS=1 with wb in the same cycle -> accepted that cycle with operands = wb data.
  - WB_BYPASS=0 -> accepted one cycle later.
- Backpressure: hold i_issue_ready=0 for 3 cycles -> bundle stable, o_instr_ready=0. Then ready=1 with a new instruction -> back-to-back issue with no bubble.
- Illegal OR x1,x2,x3 (funct3 110) -> o_illegal=1 for one cycle, o_issue_valid stays 0. Assert i_rst_n=0 mid-FULL -> o_issue_valid=0 immediately and busy cleared.
